regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Owns the single write port (WE3/A3/WD3) of the 32x32 register file.
- Shares that port between two requesters: port 0 is core writeback and port 1 is the debug/program-loader path. Each uses a valid/ready handshake.
- Also sequences a hardware clear of x1..x(NREGS-1) after reset or on request.
- Sits between the writeback/debug logic and register_file. The read ports (A1/A2/RD1/RD2) are untouched.

Parameters:
- DATA_W, 32, register data width (WD3 width)
- ADDR_W, 5, register address width (A3 width)
- NREGS, 32, number of registers; clear sweeps 1..NREGS-1

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- clr_req  in  1  single-cycle pulse; re-run the clear sweep
- req0_valid  in  1  core writeback request
- req0_addr  in  ADDR_W  destination register
- req0_data  in  DATA_W  write data
- req0_ready  out  1  port-0 request accepted this cycle
- req1_valid  in  1  debug/loader request
- req1_addr  in  ADDR_W  destination register
- req1_data  in  DATA_W  write data
- req1_ready  out  1  port-1 request accepted this cycle
- WE3  out  1  register-file write enable (registered)
- A3  out  ADDR_W  register-file write address (registered)
- WD3  out  DATA_W  register-file write data (registered)
- busy  out  1  high while the clear sweep is in progress (registered)

Behaviour:
- Reset (clk edge with rst=1), all registered outputs:
  - state=CLEAR, clr_addr=1
  - WE3=0, A3=0, WD3=0, busy=1
  - last_grant=1, so port 0 wins the first contested cycle
- req0_ready and req1_ready are combinational but forced 0 while rst=1.
- rst asserted at any time, including mid-sweep or mid-transfer, restarts the sweep at x1. Any accepted-but-unwritten request is dropped.
- CLEAR state, each cycle:
  - Register WE3=1, A3=clr_addr, WD3=0; then clr_addr++.
  - After the write to NREGS-1 is registered, go to RUN. That is exactly NREGS-1 consecutive write cycles (31 by default).
  - busy=1 throughout; drops to 0 in the first RUN cycle.
  - Both readys are 0; inputs are ignored.
- RUN state, grant (combinational, from valids and last_grant):
  - Only one valid: that port is granted.
  - Both valid with RR_ARB_EN: grant the port not equal to last_grant.
  - No valid: no grant.
  - reqN_ready = (state==RUN) && !clr_req && grant==N.
- Transfer = valid && ready. On a transfer, next edge:
  - A3/WD3 take that port's addr/data.
  - WE3=1 unless addr==0. Writes to x0 are accepted (ready=1) but registered with WE3=0.
  - last_grant updates to the granted port.
- Latency and throughput:
  - Transfer in cycle N gives WE3 high during cycle N+1; register_file commits at the end of N+1.
  - One write per cycle sustained; no bubbles between back-to-back transfers.
- No transfer in a RUN cycle: WE3=0; A3/WD3 hold their previous values.
- Requester rule: once valid is asserted, addr/data and valid stay stable until ready. The arbiter does not check this.
- clr_req in RUN:
  - Readys are 0 that cycle.
  - Next state is CLEAR with clr_addr=1; busy rises the next cycle.
  - A write registered in the same edge still completes; no partial state.
- clr_req during CLEAR is ignored; the sweep is not restarted.
- clr_addr is ADDR_W bits wide. The terminal compare is on NREGS-1, so no wrap beyond the last index.

Optional Feature:
- Macro: RR_ARB_EN.
- Defined: round-robin between ports on contention, as described above; last_grant register present.
- Undefined: fixed priority, port 0 always wins. Port 1 is granted only when req0_valid=0. last_grant register omitted; reset and latency otherwise identical.

Test Plan:
- Reset sweep: rst high 2 cycles then low. WE3=1 for 31 consecutive cycles with A3=1..31 and WD3=0; busy=1 throughout, then 0; readys 0 until busy falls.
- Single write: after clear, req0 valid addr=5 data=100 for one cycle. req0_ready=1; next cycle WE3=1, A3=5, WD3=100; reading A1=5 afterwards gives RD1=100.
- x0 drop: req1 valid addr=0 data=0xDEADBEEF. req1_ready=1, next cycle WE3=0; reading A1=0 gives RD1=0.
- Contention (RR_ARB_EN): both held valid for 4 cycles, port0 addr=1 data=7, port1 addr=2 data=8. Grants go 0,1,0,1; WE3 stays high with A3=1,2,1,2; RD1(x1)=7, RD2(x2)=8. Without the macro: grants 0,0,0,0, and req1_ready stays 0.
- clr_req mid-run: write x3=0x55, then pulse clr_req while req0 is valid. req0_ready=0 that cycle; a 31-cycle sweep follows; x3 reads 0; the held req0 is accepted once busy falls.
- Reset mid-sweep: assert rst while A3=10 in CLEAR. The sweep restarts at A3=1 and runs the full 31 writes.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Write-port owner for the 32x32 register file: arbitrates core writeback (port 0)
// against the debug/loader path (port 1) and sequences the x1..x(NREGS-1) clear sweep.
// Optional feature macro: RR_ARB_EN (round-robin on contention; fixed port-0 priority otherwise).
module regfile_write_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              WE3,
    output logic [ADDR_W-1:0] A3,
    output logic [DATA_W-1:0] WD3,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] a3_q, a3_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic              busy_q, busy_d;
`ifdef RR_ARB_EN
    logic              last_grant_q, last_grant_d;
`endif

    logic              gnt_vld;
    logic              gnt_sel;
    logic              xfer;
    logic [ADDR_W-1:0] xfer_addr;
    logic [DATA_W-1:0] xfer_data;

    // Grant selection: gnt_sel=1 means port 1 wins this cycle.
    always_comb begin
        gnt_vld = req0_valid || req1_valid;
`ifdef RR_ARB_EN
        if (req0_valid && req1_valid) begin
            gnt_sel = ~last_grant_q;
        end else begin
            gnt_sel = ~req0_valid;
        end
`else
        gnt_sel = ~req0_valid;
`endif
    end

    assign req0_ready = !rst && (state_q == ST_RUN) && !clr_req && gnt_vld && !gnt_sel;
    assign req1_ready = !rst && (state_q == ST_RUN) && !clr_req && gnt_vld && gnt_sel;
    assign xfer       = req0_ready || req1_ready;
    assign xfer_addr  = gnt_sel ? req1_addr : req0_addr;
    assign xfer_data  = gnt_sel ? req1_data : req0_data;

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        we_d       = 1'b0;
        a3_d       = a3_q;
        wd_d       = wd_q;
        busy_d     = busy_q;
`ifdef RR_ARB_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            ST_CLEAR: begin
                we_d       = 1'b1;
                a3_d       = clr_addr_q;
                wd_d       = '0;
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                busy_d     = 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b0;
                end
            end
            ST_RUN: begin
                busy_d = 1'b0;
                if (clr_req) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = ADDR_W'(1);
                    busy_d     = 1'b1;
                end else if (xfer) begin
                    // x0 writes are accepted but never enabled.
                    we_d = (xfer_addr != '0);
                    a3_d = xfer_addr;
                    wd_d = xfer_data;
`ifdef RR_ARB_EN
                    last_grant_d = gnt_sel;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= ADDR_W'(1);
            we_q       <= 1'b0;
            a3_q       <= '0;
            wd_q       <= '0;
            busy_q     <= 1'b1;
`ifdef RR_ARB_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            we_q       <= we_d;
            a3_q       <= a3_d;
            wd_q       <= wd_d;
            busy_q     <= busy_d;
`ifdef RR_ARB_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign WE3  = we_q;
    assign A3   = a3_q;
    assign WD3  = wd_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter with a behavioural register file
// fed from WE3/A3/WD3. Expectations adapt to RR_ARB_EN.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_req;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] rf [32];

    regfile_write_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .clr_req   (clr_req),
        .req0_valid(req0_valid),
        .req0_addr (req0_addr),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_addr (req1_addr),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .WE3       (WE3),
        .A3        (A3),
        .WD3       (WD3),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Register file model: x0 hardwired to zero.
    always @(posedge clk) begin
        if (WE3 && A3 != 5'd0) rf[A3] <= WD3;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic chk_clear_write(input int i);
        chk("sweep_we", 32'(WE3), 32'd1);
        chk("sweep_a3", 32'(A3), 32'(i));
        chk("sweep_wd3", WD3, 32'd0);
        chk("sweep_busy", 32'(busy), (i < 31) ? 32'd1 : 32'd0);
    endtask

    initial begin
        logic exp_g1;
        for (int r = 0; r < 32; r++) rf[r] = 32'hFFFF_FFFF;
        rf[0] = 32'd0;
        rst = 1'b1; clr_req = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'd100;
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'd0;

        // Reset values and ready gating during reset
        tick();
        tick();
        chk("rst_we", 32'(WE3), 32'd0);
        chk("rst_a3", 32'(A3), 32'd0);
        chk("rst_wd3", WD3, 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_rdy0", 32'(req0_ready), 32'd0);
        chk("rst_rdy1", 32'(req1_ready), 32'd0);
        req1_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("clr_rdy0_first", 32'(req0_ready), 32'd0);

        // Reset sweep with req0 held waiting (addr 5, data 100)
        for (int i = 1; i <= 31; i++) begin
            tick();
            chk_clear_write(i);
            chk("sweep_rdy0", 32'(req0_ready), (i < 31) ? 32'd0 : 32'd1);
        end
        tick();
        req0_valid = 1'b0;
        #1;
        chk("wr5_we", 32'(WE3), 32'd1);
        chk("wr5_a3", 32'(A3), 32'd5);
        chk("wr5_wd3", WD3, 32'd100);
        chk("x1_cleared", rf[1], 32'd0);
        tick();
        chk("idle_we", 32'(WE3), 32'd0);
        chk("idle_a3_hold", 32'(A3), 32'd5);
        chk("idle_wd3_hold", WD3, 32'd100);
        chk("rf5", rf[5], 32'd100);

        // x0 write via port 1: accepted, not enabled
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hDEAD_BEEF;
        #1;
        chk("x0_rdy1", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        chk("x0_we", 32'(WE3), 32'd0);
        chk("x0_a3", 32'(A3), 32'd0);
        chk("x0_wd3", WD3, 32'hDEAD_BEEF);
        chk("rf0", rf[0], 32'd0);

        // Contention for 4 cycles
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'd7;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'd8;
        for (int k = 0; k < 4; k++) begin
`ifdef RR_ARB_EN
            exp_g1 = (k % 2) == 1;
`else
            exp_g1 = 1'b0;
`endif
            #1;
            chk("cont_rdy0", 32'(req0_ready), 32'(!exp_g1));
            chk("cont_rdy1", 32'(req1_ready), 32'(exp_g1));
            tick();
            chk("cont_we", 32'(WE3), 32'd1);
            chk("cont_a3", 32'(A3), exp_g1 ? 32'd2 : 32'd1);
            chk("cont_wd3", WD3, exp_g1 ? 32'd8 : 32'd7);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        chk("cont_rf1", rf[1], 32'd7);
`ifdef RR_ARB_EN
        chk("cont_rf2", rf[2], 32'd8);
`else
        chk("cont_rf2", rf[2], 32'd0);
`endif

        // Write x3 = 0x55, then clr_req while req0 is pending
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h55;
        tick();
        req0_valid = 1'b0;
        tick();
        chk("rf3_written", rf[3], 32'h55);
        req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h66;
        clr_req = 1'b1;
        #1;
        chk("clrreq_rdy0", 32'(req0_ready), 32'd0);
        tick();
        clr_req = 1'b0;
        chk("clrreq_busy", 32'(busy), 32'd1);
        chk("clrreq_we", 32'(WE3), 32'd0);
        for (int i = 1; i <= 31; i++) begin
            // A clr_req pulse mid-sweep must not restart it
            clr_req = (i == 10);
            tick();
            clr_req = 1'b0;
            chk_clear_write(i);
            chk("clr2_rdy0", 32'(req0_ready), (i < 31) ? 32'd0 : 32'd1);
        end
        chk("rf3_cleared", rf[3], 32'd0);
        tick();
        req0_valid = 1'b0;
        chk("held_we", 32'(WE3), 32'd1);
        chk("held_a3", 32'(A3), 32'd4);
        chk("held_wd3", WD3, 32'h66);

        // Reset in the middle of a sweep
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 1; i <= 10; i++) tick();
        chk("mid_a3_10", 32'(A3), 32'd10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_we", 32'(WE3), 32'd0);
        chk("midrst_a3", 32'(A3), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd1);
        for (int i = 1; i <= 31; i++) begin
            tick();
            chk_clear_write(i);
        end
        tick();
        chk("final_we", 32'(WE3), 32'd0);
        chk("final_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
